sha256_nonce_sched: RTL and testbench
=====================================

SHA256_NONCE_SCHED -- requirements
Module: sha256_nonce_sched

Interface
REQ-001 The block SHALL have parameter LATENCY, default 200, giving the cycles from pipe_data presentation to the matching pipe_hash.
REQ-002 The block SHALL have parameter NONCE_STEP, default 1, giving the nonce increment per issue cycle.
REQ-003 The block SHALL have parameter NONCE_OFFSET, default 0, giving the first nonce after load.
REQ-004 The block SHALL have parameter TARGET, default 32'ha41f32e7, the hit value compared against pipe_hash.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, the number of golden-nonce entries (power of two).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port load, input, 1 bit: a one-cycle pulse that captures new work.
REQ-009 The block SHALL have port midstate_in, input, 256 bits: the first-chunk midstate.
REQ-010 The block SHALL have port data_in, input, 96 bits: header words 16..18.
REQ-011 The block SHALL have port pipe_state, output, 256 bits: the midstate held for the first hash pipe.
REQ-012 The block SHALL have port pipe_data, output, 512 bits: the second-chunk block for the first hash pipe.
REQ-013 The block SHALL have port pipe_hash, input, 32 bits: the final hash word returned from the second pipe.
REQ-014 The block SHALL have port gn_valid, output, 1 bit: the FIFO is non-empty.
REQ-015 The block SHALL have port gn_nonce, output, 32 bits: the FIFO head nonce.
REQ-016 The block SHALL have port gn_rd, input, 1 bit: pops the FIFO head; it is ignored when empty.
REQ-017 The block SHALL have port nonce_now, output, 32 bits: the nonce currently issued.
REQ-018 The block SHALL have port busy, output, 1 bit: high in FILL, RUN and DRAIN.
REQ-019 The block SHALL have port exhausted, output, 1 bit: sticky; set on entering DONE.
REQ-020 The block SHALL have port drop_cnt, output, 8 bits: a saturating count of hits lost to a full FIFO.

Function
REQ-021 pipe_data SHALL be registered with words 0..2 = data_in, word3 = nonce_now, word4 = 32'h80000000, words 5..14 = 0, word15 = 32'h00000280; word k occupies bits 32k+31:32k.
REQ-022 On load, the block SHALL capture midstate_in into pipe_state and data_in, set nonce_now and chk_nonce to NONCE_OFFSET, clear exhausted, and enter FILL; the first nonce SHALL be on pipe_data at load+1.
REQ-023 The FSM SHALL have states IDLE, FILL, RUN, DRAIN and DONE.
REQ-024 IDLE SHALL be the reset state, with no issue and no compare.
REQ-025 FILL SHALL issue a nonce every cycle, count LATENCY cycles, then move to RUN.
REQ-026 RUN SHALL issue a nonce and compare every cycle.
REQ-027 DRAIN SHALL compare without issuing for LATENCY cycles, then move to DONE.
REQ-028 DONE SHALL perform no issue and no compare, and SHALL hold pipe_data.
REQ-029 Each issue SHALL set nonce_now += NONCE_STEP; if that add carries out of 32 bits, the nonce SHALL not advance and the FSM SHALL go to DRAIN (from FILL or RUN).
REQ-030 In each compare cycle, chk_nonce SHALL be the nonce issued LATENCY cycles earlier and SHALL advance by NONCE_STEP after the compare.
REQ-031 If pipe_hash == TARGET in a compare cycle, chk_nonce SHALL be pushed; gn_valid SHALL rise on the next cycle.
REQ-032 A push to a full FIFO SHALL be discarded and SHALL increment drop_cnt, saturating at 255; a push and a pop in the same cycle on a full FIFO SHALL both succeed with no drop.
REQ-033 A load in any state SHALL restart at FILL; FIFO contents and drop_cnt SHALL be kept, and in-flight old-work results SHALL be ignored because FILL does not compare.
REQ-034 A load in the same cycle as a hit SHALL take priority; that hit SHALL be discarded and SHALL not be counted.

Reset
REQ-035 Reset SHALL put the FSM in IDLE, empty the FIFO, and set gn_valid=0, gn_nonce=0, nonce_now=0, pipe_state=0, pipe_data=0, busy=0, exhausted=0, drop_cnt=0.
REQ-036 Reset SHALL override load.

Structure
REQ-037 The shared package SHALL hold the state encoding, the padding constants 32'h80000000 and 32'h00000280, and the default TARGET.
REQ-038 The FIFO SHALL be a sub-module, gn_fifo, parameterised by depth with a 32-bit width, providing push, pop, full and empty.

Verification
REQ-039 Scenario: with LATENCY=8, a load with data_in words 1,2,3 -> at load+1 pipe_data[127:96]=0, word4=80000000, word15=00000280.
REQ-040 Scenario: a pipe model of 8 cycles driving TARGET for nonce 5 only -> gn_valid=1 with gn_nonce=5, and nothing for nonces 0..4 or 6+.
REQ-041 Scenario: NONCE_OFFSET=32'hFFFFFFF0 with NONCE_STEP=4 -> last issued FFFFFFFC, DRAIN lasts 8 cycles, then exhausted=1 and busy=0.
REQ-042 Scenario: 6 consecutive hits with FIFO_DEPTH=4 and no reads -> 4 entries kept and drop_cnt=2; then full plus a simultaneous pop and hit -> drop_cnt stays 2.
REQ-043 Scenario: reload 3 cycles into RUN while old hits are in flight -> no push during the next 8 cycles, and existing FIFO entries are unchanged.
REQ-044 Scenario: reset asserted together with load in RUN -> IDLE next cycle with all outputs 0.

Source files
------------

// File: rtl/sha256_nonce_sched_pkg.sv
// Shared definitions for the SHA-256 nonce scheduler: FSM encoding,
// second-chunk padding words and the default hit target.
package sha256_nonce_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    // Message padding for an 80-byte header: the 0x80 marker follows the
    // nonce, and the final word holds the bit length (640 = 0x280).
    localparam logic [31:0] PAD_WORD4      = 32'h8000_0000;
    localparam logic [31:0] PAD_WORD15     = 32'h0000_0280;

    localparam logic [31:0] DEFAULT_TARGET = 32'ha41f_32e7;

endpackage

// File: rtl/gn_fifo.sv
// Golden-nonce FIFO: 32-bit entries, power-of-two depth (2 or more).
// A push into a full FIFO only lands when a pop happens in the same cycle.
module gn_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero while empty so the output is defined after reset.
    assign head    = empty ? 32'd0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sha256_nonce_sched.sv
// Nonce scheduler for a two-pipe SHA-256 miner: issues one nonce per cycle
// into the first pipe, matches returning hash words against TARGET after
// LATENCY cycles, and queues the winning nonces.
module sha256_nonce_sched
    import sha256_nonce_sched_pkg::*;
#(
    parameter int unsigned LATENCY      = 200,
    parameter logic [31:0] NONCE_STEP   = 32'd1,
    parameter logic [31:0] NONCE_OFFSET = 32'd0,
    parameter logic [31:0] TARGET       = DEFAULT_TARGET,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [255:0] midstate_in,
    input  logic [95:0]  data_in,
    output logic [255:0] pipe_state,
    output logic [511:0] pipe_data,
    input  logic [31:0]  pipe_hash,
    output logic         gn_valid,
    output logic [31:0]  gn_nonce,
    input  logic         gn_rd,
    output logic [31:0]  nonce_now,
    output logic         busy,
    output logic         exhausted,
    output logic [7:0]   drop_cnt
);

    localparam int unsigned   CW       = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAT_CNT  = CW'(LATENCY);
    localparam logic [CW-1:0] LAT_LAST = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    sched_state_t  state_q;
    sched_state_t  state_d;
    logic [CW-1:0] fill_left;   // cycles until the first hash of this work returns
    logic [CW-1:0] drain_cnt;
    logic [31:0]   chk_nonce;
    logic [31:0]   nonce_sum;
    logic          nonce_carry;
    logic          issue;
    logic          advance;
    logic          compare;
    logic          hit;
    logic          fifo_full;
    logic          fifo_empty;

    assign {nonce_carry, nonce_sum} = {1'b0, nonce_now} + {1'b0, NONCE_STEP};
    assign advance  = issue && !nonce_carry;
    assign hit      = compare && (pipe_hash == TARGET);
    assign busy     = (state_q == ST_FILL) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign gn_valid = !fifo_empty;

    // Next-state and per-cycle issue/compare strobes; load overrides everything.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        compare = 1'b0;
        case (state_q)
            ST_FILL: begin
                issue = 1'b1;
                if (nonce_carry)                state_d = ST_DRAIN;
                else if (fill_left == CNT_ONE)  state_d = ST_RUN;
            end
            ST_RUN: begin
                issue   = 1'b1;
                compare = 1'b1;
                if (nonce_carry) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // If the range ran out during FILL, the early drain cycles
                // still carry hashes of earlier work and must not be compared.
                compare = (fill_left == '0);
                if (drain_cnt == LAT_LAST) state_d = ST_DONE;
            end
            default: ;
        endcase
        if (load) begin
            state_d = ST_FILL;
            issue   = 1'b0;
            compare = 1'b0;
        end
    end

    // Control state: FSM, fill/drain timers, sticky exhaustion, drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            fill_left <= '0;
            drain_cnt <= '0;
            exhausted <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            state_q <= state_d;
            if (load)                 fill_left <= LAT_CNT;
            else if (fill_left != '0) fill_left <= fill_left - 1'b1;
            if (state_q == ST_DRAIN && !load) drain_cnt <= drain_cnt + 1'b1;
            else                              drain_cnt <= '0;
            if (load)                                           exhausted <= 1'b0;
            else if (state_d == ST_DONE && state_q != ST_DONE)  exhausted <= 1'b1;
            if (hit && fifo_full && !gn_rd && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Work registers: midstate, second-chunk block, issue and check nonces.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_state <= '0;
            pipe_data  <= '0;
            nonce_now  <= '0;
            chk_nonce  <= '0;
        end else if (load) begin
            pipe_state <= midstate_in;
            pipe_data  <= {PAD_WORD15, 320'd0, PAD_WORD4, NONCE_OFFSET, data_in};
            nonce_now  <= NONCE_OFFSET;
            chk_nonce  <= NONCE_OFFSET;
        end else begin
            if (advance) begin
                nonce_now         <= nonce_sum;
                pipe_data[127:96] <= nonce_sum;
            end
            if (compare) chk_nonce <= chk_nonce + NONCE_STEP;
        end
    end

    gn_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_gn_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (hit),
        .push_data(chk_nonce),
        .pop      (gn_rd),
        .head     (gn_nonce),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Directed bench for sha256_nonce_sched: a LATENCY=8 instance driven by an
// 8-stage pipe model, plus a second instance near the top of the nonce range.
module tb_sha256_nonce_sched;

    localparam logic [31:0] TGT = 32'ha41f32e7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         load;
    logic [255:0] midstate_in;
    logic [95:0]  data_in;
    logic [255:0] pipe_state;
    logic [511:0] pipe_data;
    logic [31:0]  pipe_hash;
    logic         gn_valid;
    logic [31:0]  gn_nonce;
    logic         gn_rd;
    logic [31:0]  nonce_now;
    logic         busy;
    logic         exhausted;
    logic [7:0]   drop_cnt;

    logic         load_b;
    logic [255:0] pipe_state_b;
    logic [511:0] pipe_data_b;
    logic         gn_valid_b;
    logic [31:0]  gn_nonce_b;
    logic         gn_rd_b;
    logic [31:0]  nonce_now_b;
    logic         busy_b;
    logic         exhausted_b;
    logic [7:0]   drop_cnt_b;

    sha256_nonce_sched #(
        .LATENCY(8), .NONCE_STEP(32'd1), .NONCE_OFFSET(32'd0),
        .TARGET(TGT), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .midstate_in(midstate_in),
        .data_in(data_in), .pipe_state(pipe_state), .pipe_data(pipe_data),
        .pipe_hash(pipe_hash), .gn_valid(gn_valid), .gn_nonce(gn_nonce),
        .gn_rd(gn_rd), .nonce_now(nonce_now), .busy(busy),
        .exhausted(exhausted), .drop_cnt(drop_cnt)
    );

    sha256_nonce_sched #(
        .LATENCY(8), .NONCE_STEP(32'd4), .NONCE_OFFSET(32'hFFFF_FFF0),
        .TARGET(TGT), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset(reset), .load(load_b), .midstate_in(midstate_in),
        .data_in(data_in), .pipe_state(pipe_state_b), .pipe_data(pipe_data_b),
        .pipe_hash(~TGT), .gn_valid(gn_valid_b), .gn_nonce(gn_nonce_b),
        .gn_rd(gn_rd_b), .nonce_now(nonce_now_b), .busy(busy_b),
        .exhausted(exhausted_b), .drop_cnt(drop_cnt_b)
    );

    // Pipe model: hash word returns 8 cycles after the nonce is presented;
    // it equals TGT when the nonce lies in [hit_lo, hit_hi] and hits are on.
    logic        hit_en;
    logic [31:0] hit_lo;
    logic [31:0] hit_hi;
    logic [31:0] dly [8];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) dly[i] <= 32'd0;
        end else begin
            dly[0] <= pipe_data[127:96];
            for (int i = 1; i < 8; i++) dly[i] <= dly[i-1];
        end
    end

    assign pipe_hash = (hit_en && dly[7] >= hit_lo && dly[7] <= hit_hi) ? TGT : ~TGT;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        check_val(tag, 512'(gn_nonce), 512'(exp));
        gn_rd = 1'b1;
        tick(1);
        gn_rd = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load = 1'b0; load_b = 1'b0; gn_rd = 1'b0; gn_rd_b = 1'b0;
        midstate_in = {4{64'h0123_4567_89ab_cdef}};
        data_in = {32'd3, 32'd2, 32'd1};
        hit_en = 1'b0; hit_lo = 32'd0; hit_hi = 32'd0;
        tick(3);
        reset = 1'b0;

        // Reset state
        check_val("rst_busy",      512'(busy),       512'(0));
        check_val("rst_gn_valid",  512'(gn_valid),   512'(0));
        check_val("rst_gn_nonce",  512'(gn_nonce),   512'(0));
        check_val("rst_nonce_now", 512'(nonce_now),  512'(0));
        check_val("rst_pipe_data", pipe_data,        512'(0));
        check_val("rst_pipe_state",512'(pipe_state), 512'(0));
        check_val("rst_exhausted", 512'(exhausted),  512'(0));
        check_val("rst_drop_cnt",  512'(drop_cnt),   512'(0));
        tick(2);
        check_val("idle_no_issue", 512'(nonce_now),  512'(0));

        // Range exhaustion on the second instance: F0,F4,F8,FC then carry
        load_b = 1'b1; tick(1); load_b = 1'b0;                        // cycle 1
        check_val("ex_first_nonce", 512'(nonce_now_b), 512'(32'hFFFF_FFF0));
        check_val("ex_busy_fill",   512'(busy_b),      512'(1));
        tick(3);                                                      // cycle 4
        check_val("ex_last_nonce",  512'(nonce_now_b), 512'(32'hFFFF_FFFC));
        tick(1);                                                      // cycle 5, DRAIN
        check_val("ex_nonce_held",  512'(nonce_now_b), 512'(32'hFFFF_FFFC));
        check_val("ex_busy_drain",  512'(busy_b),      512'(1));
        tick(7);                                                      // cycle 12, last DRAIN
        check_val("ex_drain_busy",  512'(busy_b),      512'(1));
        check_val("ex_drain_exh",   512'(exhausted_b), 512'(0));
        tick(1);                                                      // cycle 13, DONE
        check_val("ex_done_busy",   512'(busy_b),      512'(0));
        check_val("ex_done_exh",    512'(exhausted_b), 512'(1));
        check_val("ex_done_word3",  512'(pipe_data_b[127:96]), 512'(32'hFFFF_FFFC));
        tick(2);
        check_val("ex_exh_sticky",  512'(exhausted_b), 512'(1));
        check_val("ex_no_hits",     512'(gn_valid_b),  512'(0));

        // Block layout and a single hit on nonce 5
        hit_lo = 32'd5; hit_hi = 32'd5; hit_en = 1'b1;
        load = 1'b1; tick(1); load = 0;                               // cycle 1
        check_val("blk_word0",  512'(pipe_data[31:0]),    512'(32'd1));
        check_val("blk_word1",  512'(pipe_data[63:32]),   512'(32'd2));
        check_val("blk_word2",  512'(pipe_data[95:64]),   512'(32'd3));
        check_val("blk_word3",  512'(pipe_data[127:96]),  512'(32'd0));
        check_val("blk_word4",  512'(pipe_data[159:128]), 512'(32'h8000_0000));
        check_val("blk_zeros",  512'(pipe_data[479:160]), 512'(0));
        check_val("blk_word15", 512'(pipe_data[511:480]), 512'(32'h0000_0280));
        check_val("blk_state",  512'(pipe_state), 512'({4{64'h0123_4567_89ab_cdef}}));
        check_val("blk_busy",   512'(busy), 512'(1));
        tick(1);                                                      // cycle 2
        check_val("issue_nonce",  512'(nonce_now),         512'(32'd1));
        check_val("issue_word3",  512'(pipe_data[127:96]), 512'(32'd1));
        tick(12);                                                     // cycle 14
        check_val("hit_not_yet",  512'(gn_valid), 512'(0));
        tick(1);                                                      // cycle 15
        check_val("hit_valid",    512'(gn_valid), 512'(1));
        check_val("hit_nonce",    512'(gn_nonce), 512'(32'd5));
        tick(20);
        check_val("hit_no_drop",  512'(drop_cnt), 512'(0));
        pop_expect("hit_head", 32'd5);
        check_val("hit_only_one", 512'(gn_valid), 512'(0));

        // Six consecutive hits (nonces 2..7) into a 4-deep FIFO
        hit_lo = 32'd2; hit_hi = 32'd7;
        load = 1'b1; tick(1); load = 1'b0;                            // cycle 1
        tick(19);                                                     // cycle 20
        check_val("full_valid", 512'(gn_valid), 512'(1));
        check_val("full_head",  512'(gn_nonce), 512'(32'd2));
        check_val("full_drops", 512'(drop_cnt), 512'(2));
        hit_lo = 32'd25; hit_hi = 32'd25;
        tick(14);                                                     // cycle 34: nonce 25 hits
        gn_rd = 1'b1; tick(1); gn_rd = 1'b0;
        check_val("pophit_drops", 512'(drop_cnt), 512'(2));
        check_val("pophit_head",  512'(gn_nonce), 512'(32'd3));
        pop_expect("pophit_pop3", 32'd3);
        check_val("pophit_next",  512'(gn_nonce), 512'(32'd4));

        // Reload three cycles into RUN; old hashes for 4..11 arrive during FILL
        hit_lo = 32'd4; hit_hi = 32'd11;
        load = 1'b1; tick(1); load = 1'b0;                            // run A cycle 1
        tick(11);                                                     // run A cycle 12
        load = 1'b1; tick(1); load = 1'b0;                            // run B cycle 1
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("reload_head_c%0d", i + 1), 512'(gn_nonce), 512'(32'd4));
            tick(1);
        end
        check_val("reload_drops", 512'(drop_cnt), 512'(2));
        hit_en = 1'b0;
        pop_expect("reload_e0", 32'd4);
        pop_expect("reload_e1", 32'd5);
        pop_expect("reload_e2", 32'd25);
        check_val("reload_empty", 512'(gn_valid), 512'(0));

        // Reset together with load while running
        hit_lo = 32'd20; hit_hi = 32'd20; hit_en = 1'b1;
        tick(18);                                                     // run B cycle 30
        check_val("pre_rst_valid", 512'(gn_valid),  512'(1));
        check_val("pre_rst_head",  512'(gn_nonce),  512'(32'd20));
        check_val("pre_rst_nonce", 512'(nonce_now), 512'(32'd29));
        reset = 1'b1; load = 1'b1; tick(1); reset = 1'b0; load = 1'b0;
        check_val("rl_busy",       512'(busy),       512'(0));
        check_val("rl_gn_valid",   512'(gn_valid),   512'(0));
        check_val("rl_gn_nonce",   512'(gn_nonce),   512'(0));
        check_val("rl_nonce_now",  512'(nonce_now),  512'(0));
        check_val("rl_pipe_data",  pipe_data,        512'(0));
        check_val("rl_pipe_state", 512'(pipe_state), 512'(0));
        check_val("rl_exhausted",  512'(exhausted),  512'(0));
        check_val("rl_drop_cnt",   512'(drop_cnt),   512'(0));
        tick(2);
        check_val("rl_idle_nonce", 512'(nonce_now),  512'(0));
        check_val("rl_idle_busy",  512'(busy),       512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
